// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the reg_file_sb register file / pending-write scoreboard.
//   REG_NUM    number of GPRs (index 0 reads as zero and is never written)
//   DATA_W     register width
//   PEND_W     pending-counter width; up to 2**PEND_W-1 writers in flight per reg
//   REG_ADDR_W register address width
//   ZERO_WORD  all-zero data word
// Optional feature macro: REG_FILE_BYPASS_EN (see reg_file_sb.sv).
package reg_file_sb_pkg;

  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;
  localparam int PEND_W     = 2;
  localparam int REG_ADDR_W = $clog2(REG_NUM);

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // An operand is still busy unless the only outstanding writer commits this cycle.
  function automatic logic operand_busy(input logic nz, input logic last_one, input logic commit_hit);
    return nz && !(last_one && commit_hit);
  endfunction

endpackage

// File: rtl/reg_file_sb_pend_ctr.sv
// Per-register pending-write counter.
//   clk, rst_n  clock, async active-low reset
//   inc_i       a writer to this reg was issued
//   dec_i       a writer to this reg committed
//   clr_i       flush: drop every in-flight writer (wins over inc/dec)
//   cnt_o       current count
//   nz_o        at least one writer outstanding
//   full_o      count at maximum
// Saturates at both ends; inc and dec together leave the count unchanged.
module reg_file_sb_pend_ctr
  import reg_file_sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              clr_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              nz_o,
  output logic              full_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q;
  logic [PEND_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign nz_o   = (cnt_q != '0);
  assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_file_sb.sv
// GPR array (32x32, $0 hard-wired zero) with two combinational read ports,
// one write-back port and a per-register pending-write scoreboard.
//   clk, rst_n                       clock, async active-low reset
//   read_en_x / read_addr_x          operand read request (x = 1, 2)
//   read_data_x                      operand data, combinational
//   issue_valid / issue_write_en /
//   issue_write_addr                 ID issue; marks destination pending
//   write_en / write_addr /
//   write_data                       WB commit; writes array, clears one pending mark
//   flush                            cancel all in-flight writers
//   stall_req                        operand hazard or pending counter full
// Macro REG_FILE_BYPASS_EN: when defined, a same-cycle commit is forwarded to
// matching reads and releases the hazard in that cycle; when undefined reads
// see the pre-write array value and release one cycle later.
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en_1,
  input  logic [REG_ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0]     read_data_1,
  input  logic                  read_en_2,
  input  logic [REG_ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0]     read_data_2,
  input  logic                  issue_valid,
  input  logic                  issue_write_en,
  input  logic [REG_ADDR_W-1:0] issue_write_addr,
  input  logic                  write_en,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  flush,
  output logic                  stall_req
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  logic [REG_NUM-1:0][PEND_W-1:0] cnt;
  logic [REG_NUM-1:0]             nz;
  logic [REG_NUM-1:0]             full;

  logic hazard_1;
  logic hazard_2;
  logic full_hit;

  // $0 never has a pending writer.
  assign cnt[0]  = '0;
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = issue_valid && issue_write_en && (issue_write_addr == REG_ADDR_W'(r)) && !stall_req;
    assign dec = write_en && (write_addr == REG_ADDR_W'(r));

    reg_file_sb_pend_ctr u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (inc),
      .dec_i  (dec),
      .clr_i  (flush),
      .cnt_o  (cnt[r]),
      .nz_o   (nz[r]),
      .full_o (full[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else if (write_en && (write_addr != '0)) begin
      regs_q[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = ZERO_WORD;
    if (rst_n && read_en_1 && (read_addr_1 != '0)) begin
      read_data_1 = regs_q[read_addr_1];
`ifdef REG_FILE_BYPASS_EN
      if (write_en && (write_addr == read_addr_1)) begin
        read_data_1 = write_data;
      end
`endif
    end
  end

  always_comb begin
    read_data_2 = ZERO_WORD;
    if (rst_n && read_en_2 && (read_addr_2 != '0)) begin
      read_data_2 = regs_q[read_addr_2];
`ifdef REG_FILE_BYPASS_EN
      if (write_en && (write_addr == read_addr_2)) begin
        read_data_2 = write_data;
      end
`endif
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign hazard_1 = read_en_1 && (read_addr_1 != '0) &&
                    operand_busy(nz[read_addr_1], cnt[read_addr_1] == PEND_W'(1),
                                 write_en && (write_addr == read_addr_1));
  assign hazard_2 = read_en_2 && (read_addr_2 != '0) &&
                    operand_busy(nz[read_addr_2], cnt[read_addr_2] == PEND_W'(1),
                                 write_en && (write_addr == read_addr_2));
`else
  assign hazard_1 = read_en_1 && (read_addr_1 != '0) && nz[read_addr_1];
  assign hazard_2 = read_en_2 && (read_addr_2 != '0) && nz[read_addr_2];
`endif

  // A commit to the same destination frees a slot, so a full counter can still accept the issue.
  assign full_hit = issue_valid && issue_write_en && full[issue_write_addr] &&
                    !(write_en && (write_addr == issue_write_addr));

  assign stall_req = rst_n && (hazard_1 || hazard_2 || full_hit);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;
  logic        issue_valid;
  logic        issue_write_en;
  logic [4:0]  issue_write_addr;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        flush;
  logic        stall_req;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_en_1        (read_en_1),
    .read_addr_1      (read_addr_1),
    .read_data_1      (read_data_1),
    .read_en_2        (read_en_2),
    .read_addr_2      (read_addr_2),
    .read_data_2      (read_data_2),
    .issue_valid      (issue_valid),
    .issue_write_en   (issue_write_en),
    .issue_write_addr (issue_write_addr),
    .write_en         (write_en),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .flush            (flush),
    .stall_req        (stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares outputs at the falling edge against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (read_data_1 !== e.d1) begin
        fails++;
        $display("FAIL %s read_data_1 got %h expected %h", e.name, read_data_1, e.d1);
      end
      checks++;
      if (read_data_2 !== e.d2) begin
        fails++;
        $display("FAIL %s read_data_2 got %h expected %h", e.name, read_data_2, e.d2);
      end
      checks++;
      if (stall_req !== e.st) begin
        fails++;
        $display("FAIL %s stall_req got %b expected %b", e.name, stall_req, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string name, input logic [31:0] d1, input logic [31:0] d2, input logic st);
    exp_t e;
    e.name = name; e.d1 = d1; e.d2 = d2; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en_1 = 0; read_addr_1 = 0; read_en_2 = 0; read_addr_2 = 0;
    issue_valid = 0; issue_write_en = 0; issue_write_addr = 0;
    write_en = 0; write_addr = 0; write_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1; issue_write_en = 1; issue_write_addr = a;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d);
    write_en = 1; write_addr = a; write_data = d;
  endtask

  initial begin
    rst_n = 0;
    idle();
    #1;
    expect_out("reset_state", 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1;

    // $0 is never written and never pending
    commit(5'd0, 32'h1234); issue(5'd0); read_en_1 = 1; read_addr_1 = 5'd0;
    expect_out("zero_write_issue", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    read_en_1 = 1; read_addr_1 = 5'd0; issue(5'd0);
    expect_out("zero_read_after", 32'h0, 32'h0, 1'b0);
    tick(); idle();

    // commit with no pending writer: no underflow
    commit(5'd4, 32'hA5A5_0004); read_en_2 = 1; read_addr_2 = 5'd4;
    expect_out("commit_cnt0", 32'h0, BYP ? 32'hA5A5_0004 : 32'h0, 1'b0);
    tick(); idle();
    read_en_2 = 1; read_addr_2 = 5'd4;
    expect_out("cnt0_no_underflow", 32'h0, 32'hA5A5_0004, 1'b0);
    tick(); idle();
    read_en_1 = 0; read_addr_1 = 5'd4; read_en_2 = 1; read_addr_2 = 5'd4;
    expect_out("read_en_low", 32'h0, 32'hA5A5_0004, 1'b0);
    tick(); idle();

    // RAW hazard on $3
    issue(5'd3);
    expect_out("issue3", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    read_en_1 = 1; read_addr_1 = 5'd3;
    expect_out("haz3_a", 32'h0, 32'h0, 1'b1);
    tick();
    expect_out("haz3_b", 32'h0, 32'h0, 1'b1);
    tick();
    commit(5'd3, 32'hDEAD_BEEF);
    expect_out("haz3_commit", BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1);
    tick();
    write_en = 0;
    expect_out("haz3_after", 32'hDEAD_BEEF, 32'h0, 1'b0);
    tick(); idle();

    // pending counter saturation on $7
    for (int i = 0; i < 3; i++) begin
      issue(5'd7);
      expect_out("issue7", 32'h0, 32'h0, 1'b0);
      tick();
    end
    expect_out("issue7_full", 32'h0, 32'h0, 1'b1);
    tick(); idle();
    read_en_2 = 1; read_addr_2 = 5'd7;
    expect_out("haz7_port2", 32'h0, 32'h0, 1'b1);
    tick(); idle();
    issue(5'd7); commit(5'd7, 32'h0000_0077);
    expect_out("issue7_with_commit", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    issue(5'd7);
    expect_out("issue7_still_full", 32'h0, 32'h0, 1'b1);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      commit(5'd7, 32'h70 + 32'(i));
      expect_out("drain7", 32'h0, 32'h0, 1'b0);
      tick();
    end
    idle();
    read_en_2 = 1; read_addr_2 = 5'd7;
    expect_out("read7_drained", 32'h0, 32'h0000_0072, 1'b0);
    tick(); idle();

    // flush with concurrent commit
    issue(5'd9);
    expect_out("issue9_a", 32'h0, 32'h0, 1'b0);
    tick();
    expect_out("issue9_b", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    flush = 1; commit(5'd9, 32'h55);
    expect_out("flush_commit", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    read_en_1 = 1; read_addr_1 = 5'd9;
    expect_out("read9_after_flush", 32'h55, 32'h0, 1'b0);
    tick(); idle();

    // dual-port read of distinct registers
    read_en_1 = 1; read_addr_1 = 5'd4; read_en_2 = 1; read_addr_2 = 5'd3;
    expect_out("dual_read", 32'hA5A5_0004, 32'hDEAD_BEEF, 1'b0);
    tick(); idle();

    // reset mid-run with $5 pending twice
    issue(5'd5);
    expect_out("issue5_a", 32'h0, 32'h0, 1'b0);
    tick();
    expect_out("issue5_b", 32'h0, 32'h0, 1'b0);
    tick(); idle();
    rst_n = 0;
    read_en_1 = 1; read_addr_1 = 5'd5; read_en_2 = 1; read_addr_2 = 5'd3;
    commit(5'd3, 32'h1111_2222);
    expect_out("in_reset", 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1; write_en = 0;
    expect_out("after_reset", 32'h0, 32'h0, 1'b0);
    tick(); idle();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain leftover %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
